// File: rtl/conv_output_collector.sv
// Collects y results from the last PE of a convolution chain, skips the
// pipeline-fill outputs, saturates to OUT_W and buffers them in a FWFT FIFO.
module conv_output_collector #(
    parameter int TAPS       = 3,
    parameter int ACC_W      = 32,
    parameter int OUT_W      = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [CNT_W-1:0]        n_samples,
    input  logic signed [ACC_W-1:0] y_in,
    input  logic                    y_in_valid,
    output logic [OUT_W-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] WARM  = CNT_W'(TAPS - 1);
    localparam logic [PW:0]      FULLC = (PW + 1)'(FIFO_DEPTH);
    localparam logic [OUT_W-1:0] MAXV  = {1'b0, {(OUT_W - 1){1'b1}}};
    localparam logic [OUT_W-1:0] MINV  = {1'b1, {(OUT_W - 1){1'b0}}};

    typedef enum logic [1:0] {IDLE, WARMUP, COLLECT, DRAIN} state_t;

    state_t           state;
    logic [CNT_W-1:0] n_lat;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic [OUT_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]    wp;
    logic [PW-1:0]    rp;
    logic [PW:0]      occ;
    logic             push_req;
    logic             pop;
    logic             full;
    logic             accept;
    logic [ACC_W-OUT_W:0] hi;
    logic [OUT_W-1:0] sat_y;

    // In range exactly when the bits above the output sign bit are all
    // copies of it.
    assign hi     = y_in[ACC_W-1:OUT_W-1];
    assign sat_y  = (&hi || ~|hi) ? y_in[OUT_W-1:0]
                  : (y_in[ACC_W-1] ? MINV : MAXV);

    assign cnt_nx    = cnt + CNT_W'(1);
    assign out_valid = (occ != '0);
    assign out_data  = out_valid ? mem[rp] : '0;
    assign full      = (occ == FULLC);
    assign pop       = out_valid && out_ready;
    assign push_req  = (state == COLLECT) && y_in_valid;
    assign accept    = push_req && (!full || pop);

    always_ff @(posedge clk) begin
        if (accept) mem[wp] <= sat_y;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp  <= '0;
            rp  <= '0;
            occ <= '0;
        end else begin
            if (accept) wp <= wp + PW'(1);
            if (pop)    rp <= rp + PW'(1);
            if (accept && !pop)      occ <= occ + (PW + 1)'(1);
            else if (pop && !accept) occ <= occ - (PW + 1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            n_lat    <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            if (push_req && full && !pop) overflow <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        n_lat    <= n_samples;
                        cnt      <= '0;
                        overflow <= 1'b0;
                        busy     <= 1'b1;
                        state    <= WARMUP;
                    end
                end
                WARMUP: begin
                    // Leave on the edge that takes the last fill sample so
                    // the first real result lands in COLLECT.
                    if (cnt == n_lat) begin
                        state <= DRAIN;
                    end else if (cnt == WARM) begin
                        state <= COLLECT;
                    end else if (y_in_valid) begin
                        cnt <= cnt_nx;
                        if (cnt_nx == n_lat)     state <= DRAIN;
                        else if (cnt_nx == WARM) state <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (y_in_valid) begin
                        cnt <= cnt_nx;
                        if (cnt_nx == n_lat) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (occ == '0 || (occ == (PW + 1)'(1) && pop)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_output_collector.sv
// Directed self-checking bench for conv_output_collector
// (TAPS=3, ACC_W=32, OUT_W=16, FIFO_DEPTH=4).
module tb_conv_output_collector;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] n_samples;
    logic signed [31:0] y_in;
    logic        y_in_valid;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic        overflow;

    int n_tests;
    int n_fail;
    int done_cnt;
    bit valid_seen;
    logic [15:0] got_q [$];
    logic [15:0] exp_q [$];

    conv_output_collector #(
        .TAPS(3), .ACC_W(32), .OUT_W(16), .FIFO_DEPTH(4), .CNT_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .n_samples(n_samples),
        .y_in(y_in), .y_in_valid(y_in_valid), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
        .done(done), .overflow(overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Observe on the falling edge: a valid&ready seen here pops next edge.
    always @(negedge clk) begin
        if (out_valid && out_ready) got_q.push_back(out_data);
        if (done) done_cnt++;
        if (out_valid) valid_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input int n);
        n_samples = 16'(n);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic feed(input int v);
        y_in = 32'(v);
        y_in_valid = 1'b1;
        step();
        y_in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int base;
        base = done_cnt;
        for (int i = 0; i < 40; i++) begin
            if (done_cnt != base) break;
            step();
        end
        repeat (3) step();
        check(tag, 32'(done_cnt - base), 32'd1);
    endtask

    task automatic check_outputs(input string tag);
        check(tag, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check(tag, 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete();
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        done_cnt = 0;
        valid_seen = 1'b0;
        rst_n = 1'b0;
        start = 1'b0;
        n_samples = '0;
        y_in = '0;
        y_in_valid = 1'b0;
        out_ready = 1'b0;
        #2;
        check("rst_valid", 32'(out_valid), 0);
        check("rst_data", 32'(out_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_ovf", 32'(overflow), 0);
        #10 rst_n = 1'b1;

        // Basic frame: 10..14 -> 12,13,14
        out_ready = 1'b1;
        start_frame(5);
        check("busy_run", 32'(busy), 1);
        for (int i = 10; i <= 14; i++) feed(i);
        wait_done("basic_done");
        exp_q = '{16'd12, 16'd13, 16'd14};
        check_outputs("basic_out");
        check("basic_ovf", 32'(overflow), 0);
        check("basic_busy", 32'(busy), 0);

        // Saturation
        start_frame(5);
        feed(0); feed(0);
        feed(40000); feed(-40000); feed(-5);
        wait_done("sat_done");
        exp_q = '{16'h7fff, 16'h8000, 16'hfffb};
        check_outputs("sat_out");

        // Overflow: 7 results, 4 kept
        out_ready = 1'b0;
        start_frame(9);
        feed(0); feed(0);
        for (int i = 1; i <= 7; i++) feed(i);
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_valid", 32'(out_valid), 1);
        check("ovf_head", 32'(out_data), 1);
        repeat (3) step();
        check("ovf_stable", 32'(out_data), 1);
        out_ready = 1'b1;
        wait_done("ovf_done");
        exp_q = '{16'd1, 16'd2, 16'd3, 16'd4};
        check_outputs("ovf_out");
        check("ovf_sticky", 32'(overflow), 1);

        // Short frames produce nothing
        valid_seen = 1'b0;
        start_frame(2);
        check("ovf_clear", 32'(overflow), 0);
        feed(50); feed(51);
        wait_done("short_done");
        check("short_valid", 32'(valid_seen), 0);
        check("short_busy", 32'(busy), 0);
        start_frame(0);
        wait_done("zero_done");
        feed(99);
        step();
        check("zero_valid", 32'(valid_seen), 0);

        // Push into full FIFO with simultaneous pop
        out_ready = 1'b0;
        start_frame(7);
        feed(0); feed(0);
        for (int i = 1; i <= 4; i++) feed(i);
        out_ready = 1'b1;
        feed(5);
        out_ready = 1'b0;
        check("fp_ovf", 32'(overflow), 0);
        check("fp_head", 32'(out_data), 2);
        out_ready = 1'b1;
        wait_done("fp_done");
        exp_q = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
        check_outputs("fp_out");

        // Asynchronous reset mid-COLLECT with 2 entries buffered
        out_ready = 1'b0;
        start_frame(9);
        feed(0); feed(0); feed(21); feed(22);
        check("pre_rst_valid", 32'(out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 0);
        check("arst_data", 32'(out_data), 0);
        check("arst_busy", 32'(busy), 0);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        got_q.delete();
        step();
        start_frame(4);
        feed(0); feed(0); feed(77); feed(88);
        wait_done("post_done");
        exp_q = '{16'd77, 16'd88};
        check_outputs("post_out");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_output_collector.md
CONV_OUTPUT_COLLECTOR -- requirements
Module: conv_output_collector

Interface
REQ-001 The block SHALL take these parameters: TAPS, default 3, PE chain length (kernel taps); ACC_W, default 32, accumulator width of y from the last PE; OUT_W, default 16, output sample width; FIFO_DEPTH, default 4, output buffer entries (power of two); CNT_W, default 16, sample-count width.
REQ-002 The block SHALL have one clock and an asynchronous active-low reset, with these ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  frame start pulse
- n_samples  in  CNT_W  number of x samples in the frame
- y_in  in  ACC_W  signed partial sum from the last PE y_out
- y_in_valid  in  1  y_in carries a new result this cycle
- out_data  out  OUT_W  signed saturated result
- out_valid  out  1  out_data holds an unconsumed result
- out_ready  in  1  consumer accepts out_data
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle frame-complete pulse
- overflow  out  1  sticky flag; a result was dropped

Function
REQ-003 The FSM SHALL have four states: IDLE, WARMUP, COLLECT, DRAIN.
REQ-004 In IDLE, start=1 SHALL latch n_samples and zero the input counter; the next state SHALL be WARMUP. It SHALL also clear overflow.
REQ-005 start SHALL be ignored outside IDLE.
REQ-006 In WARMUP, each y_in_valid SHALL increment the input counter and SHALL discard the data (pipeline fill).
- After TAPS-1 accepted inputs: next state COLLECT.
- If the counter reaches n_samples first: next state DRAIN.
REQ-007 In COLLECT, each y_in_valid SHALL increment the input counter and push sat(y_in) into the FIFO. When the counter reaches n_samples, the next state SHALL be DRAIN.
REQ-008 n_samples=0 SHALL go IDLE->WARMUP->DRAIN with no input consumed.
REQ-009 n_samples<TAPS SHALL produce zero outputs.
REQ-010 n_samples>=TAPS SHALL produce exactly n_samples-TAPS+1 pushes.
REQ-011 sat() SHALL be signed saturation of ACC_W to OUT_W:
- y_in > 2^(OUT_W-1)-1 -> 2^(OUT_W-1)-1
- y_in < -2^(OUT_W-1) -> -2^(OUT_W-1)
- otherwise the low OUT_W bits.
REQ-012 The FIFO SHALL be first-word-fall-through with registered storage. A push at edge t SHALL be visible on out_data/out_valid after edge t (one-cycle latency) when the FIFO was empty.
REQ-013 A pop SHALL occur on an edge where out_valid=1 and out_ready=1.
REQ-014 out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-015 Push when full with no pop in the same cycle SHALL drop the sample and set overflow. The input counter SHALL still increment.
REQ-016 Push when full with a simultaneous pop SHALL be accepted, with no overflow and occupancy unchanged.
REQ-017 Read and write pointers SHALL wrap modulo FIFO_DEPTH. full and empty SHALL be derived from an occupancy count of 0..FIFO_DEPTH.
REQ-018 y_in_valid in IDLE or DRAIN SHALL be ignored.
REQ-019 In DRAIN, when the FIFO is empty (including via a pop this edge), the next state SHALL be IDLE with done=1 for exactly that one cycle.
REQ-020 busy SHALL be 0 in IDLE and 1 in WARMUP, COLLECT and DRAIN.

Reset
REQ-021 rst_n=0 SHALL immediately force, regardless of clk:
- state = IDLE
- FIFO empty (pointers and occupancy 0)
- counters = 0
- out_data = 0, out_valid = 0, busy = 0, done = 0, overflow = 0
REQ-022 Reset asserted mid-frame SHALL abandon the frame. No stale FIFO entry SHALL appear after rst_n rises.
REQ-023 The first start SHALL be honoured on the first rising edge after rst_n deasserts.

Verification
REQ-024 TAPS=3, n_samples=5, y_in=10,11,12,13,14 on consecutive valid cycles, out_ready=1 -> out_data 12,13,14 in order; one done pulse after the last pop; overflow=0.
REQ-025 OUT_W=16, y_in=40000, -40000, -5 in COLLECT -> out_data 32767, -32768, -5.
REQ-026 FIFO_DEPTH=4, n_samples=9 (7 results), out_ready=0 -> 4 entries held; overflow=1; 3 dropped. Then raising out_ready -> results 1-4 in order, then done.
REQ-027 n_samples=2 with TAPS=3 -> two inputs consumed; out_valid never asserted; done pulse; busy returns to 0.
REQ-028 FIFO full, with y_in_valid, out_valid and out_ready all 1 on the same edge -> new sample stored; overflow stays 0; occupancy stays 4.
REQ-029 rst_n pulsed low mid-COLLECT with 2 entries buffered -> all outputs 0 asynchronously; a subsequent frame yields only its own results.
